// File: rtl/wp_reg_port_ctrl_pkg.sv
// Shared wavepool constants and controller state type.
package wp_reg_port_ctrl_pkg;

  localparam int unsigned NUM_ENTRIES = 40;
  localparam int unsigned DATA_W      = 35;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned NUM_WR      = 3;
  localparam int unsigned NUM_RD      = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/wp_reg_port_ctrl_rr_arbiter_3.sv
// Three-way round-robin arbiter; the requester after the last winner has top priority.
module rr_arbiter_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       update,
  output logic [2:0] gnt
);

  logic [1:0] ptr_q, ptr_d;

  // Grant search starting at the priority pointer; pointer advances past the winner
  always_comb begin
    gnt = '0;
    case (ptr_q)
      2'd1: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase

    ptr_d = ptr_q;
    if (update) begin
      case (gnt)
        3'b001:  ptr_d = 2'd1;
        3'b010:  ptr_d = 2'd2;
        3'b100:  ptr_d = 2'd0;
        default: ptr_d = ptr_q;
      endcase
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wp_reg_port_ctrl.sv
// Register-file port controller: clear sweep after reset, then RR write / fixed-priority read.
module wp_reg_port_ctrl #(
  parameter int unsigned NUM_ENTRIES = wp_reg_port_ctrl_pkg::NUM_ENTRIES,
  parameter int unsigned DATA_W      = wp_reg_port_ctrl_pkg::DATA_W,
  parameter int unsigned ADDR_W      = wp_reg_port_ctrl_pkg::ADDR_W,
  parameter int unsigned NUM_WR      = wp_reg_port_ctrl_pkg::NUM_WR,
  parameter int unsigned NUM_RD      = wp_reg_port_ctrl_pkg::NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wr_data,
  output logic [NUM_WR-1:0]            wr_gnt,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic                         rd_valid,
  output logic [$clog2(NUM_RD)-1:0]    rd_id,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rf_wr_en,
  output logic [ADDR_W-1:0]            rf_wr_addr,
  output logic [DATA_W-1:0]            rf_wr_data,
  output logic [ADDR_W-1:0]            rf_rd_addr,
  input  logic [DATA_W-1:0]            rf_rd_data,
  output logic                         init_done,
  output logic                         addr_err
);

  import wp_reg_port_ctrl_pkg::*;

  localparam int unsigned       RD_ID_W   = $clog2(NUM_RD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

  ctrl_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [RD_ID_W-1:0]  rd_id_q, rd_id_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                addr_err_q, addr_err_d;

  logic                run, sweeping, wr_any, rd_any;
  logic [NUM_WR-1:0]   wr_req_run;
  logic [ADDR_W-1:0]   wr_sel_addr, rd_sel_addr;
  logic [DATA_W-1:0]   wr_sel_data;
  logic [RD_ID_W-1:0]  rd_sel_id;

  // rst also gates live outputs, so a reset cycle neither grants nor issues a pending write
  assign run        = (state_q == ST_RUN)  && !rst;
  assign sweeping   = (state_q == ST_INIT) && !rst;
  assign wr_req_run = run ? wr_req : '0;

  rr_arbiter_3 u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (wr_req_run),
    .update (run),
    .gnt    (wr_gnt)
  );

  // Mux the granted write requester's address and data
  always_comb begin
    wr_sel_addr = '0;
    wr_sel_data = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (wr_gnt[i]) begin
        wr_sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
        wr_sel_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Fixed-priority read grant: descending scan so the lowest index wins
  always_comb begin
    rd_gnt      = '0;
    rd_sel_addr = '0;
    rd_sel_id   = '0;
    if (run) begin
      for (int unsigned i = NUM_RD; i > 0; i--) begin
        if (rd_req[i-1]) begin
          rd_gnt        = '0;
          rd_gnt[i-1]   = 1'b1;
          rd_sel_addr   = rd_addr[(i-1)*ADDR_W +: ADDR_W];
          rd_sel_id     = RD_ID_W'(i-1);
        end
      end
    end
  end

  assign wr_any     = |wr_gnt;
  assign rd_any     = |rd_gnt;
  assign rf_rd_addr = rd_sel_addr;

  // Next-state: sweep sequencing, registered write issue, read return, error pulse
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    wr_en_d    = wr_any && (wr_sel_addr <= LAST_ADDR);
    wr_addr_d  = wr_sel_addr;
    wr_data_d  = wr_sel_data;
    rd_valid_d = rd_any;
    rd_id_d    = rd_any ? rd_sel_id : rd_id_q;
    rd_data_d  = rd_data_q;
    if (rd_any) rd_data_d = (rd_sel_addr <= LAST_ADDR) ? rf_rd_data : '0;
    addr_err_d = (wr_any && (wr_sel_addr > LAST_ADDR)) ||
                 (rd_any && (rd_sel_addr > LAST_ADDR));
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_data_q  <= rd_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rf_wr_en   = sweeping || (wr_en_q && !rst);
  assign rf_wr_addr = sweeping ? sweep_q : wr_addr_q;
  assign rf_wr_data = sweeping ? '0 : wr_data_q;
  assign init_done  = run;
  assign rd_valid   = rd_valid_q;
  assign rd_id      = rd_id_q;
  assign rd_data    = rd_data_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_wp_reg_port_ctrl.sv
// Bench for wp_reg_port_ctrl: register-file model plus a behavioural arbitration/memory model.
module tb_wp_reg_port_ctrl;

  localparam int unsigned NE = 40;
  localparam int unsigned DW = 35;
  localparam int unsigned AW = 6;
  localparam int unsigned NW = 3;
  localparam int unsigned NR = 2;
  localparam logic [AW-1:0] NE_A = 6'd40;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    wr_req;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    wr_gnt;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_gnt;
  logic             rd_valid;
  logic [0:0]       rd_id;
  logic [DW-1:0]    rd_data;
  logic             rf_wr_en;
  logic [AW-1:0]    rf_wr_addr;
  logic [DW-1:0]    rf_wr_data;
  logic [AW-1:0]    rf_rd_addr;
  logic [DW-1:0]    rf_rd_data;
  logic             init_done;
  logic             addr_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  wp_reg_port_ctrl #(
    .NUM_ENTRIES(NE), .DATA_W(DW), .ADDR_W(AW), .NUM_WR(NW), .NUM_RD(NR)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .init_done(init_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // External register file: async read, sync write; prefill puts junk in before the first sweep
  logic          prefill;
  logic [DW-1:0] rf_mem [NE];
  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < NE; i++) rf_mem[i] <= DW'({$urandom(), $urandom()}) | 35'h1;
    end else if (rf_wr_en && rf_wr_addr < NE_A) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data = (rf_rd_addr < NE_A) ? rf_mem[rf_rd_addr] : 35'h5_DEAD_BEEF;

  // Reference model state
  int            rr_ptr;
  logic [DW-1:0] mdl_mem [NE];
  logic          pend_v;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic [DW-1:0] prev_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Called at a falling edge; holds rst for the given number of cycles and releases it
  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1; wr_req = '0; rd_req = '0;
    for (int unsigned c = 0; c < cycles; c++) begin
      #1;
      chk("rst_rf_wr_en", 64'(rf_wr_en), 64'(0));
      chk("rst_wr_gnt", 64'(wr_gnt), 64'(0));
      chk("rst_init_done", 64'(init_done), 64'(0));
      @(posedge clk); #1;
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_id", 64'(rd_id), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_addr_err", 64'(addr_err), 64'(0));
      @(negedge clk);
    end
    rr_ptr = 0; pend_v = 1'b0; prev_rd = '0;
    for (int i = 0; i < NE; i++) mdl_mem[i] = '0;
    rst = 1'b0; wr_req = '1; rd_req = '1;
  endtask

  // Sweep cycles: every requester is asking, nothing may be granted
  task automatic sweep_check(input int unsigned n);
    for (int unsigned c = 0; c < n; c++) begin
      #1;
      chk("sweep_en", 64'(rf_wr_en), 64'(1));
      chk("sweep_addr", 64'(rf_wr_addr), 64'(c));
      chk("sweep_data", 64'(rf_wr_data), 64'(0));
      chk("sweep_wr_gnt", 64'(wr_gnt), 64'(0));
      chk("sweep_rd_gnt", 64'(rd_gnt), 64'(0));
      chk("sweep_rd_addr", 64'(rf_rd_addr), 64'(0));
      chk("sweep_init_done", 64'(init_done), 64'(0));
      @(negedge clk);
    end
  endtask

  // One RUN cycle, driven at a falling edge, checked against the model
  task automatic run_cycle(input logic [NW-1:0] wq, input logic [NW*AW-1:0] wa,
                           input logic [NW*DW-1:0] wd, input logic [NR-1:0] rq,
                           input logic [NR*AW-1:0] ra);
    int            wi, ri, c;
    logic [AW-1:0] w_a, r_a;
    logic [DW-1:0] w_d, exp_rd;
    logic          w_ok;
    wr_req = wq; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
    wi = -1;
    for (int k = 0; k < NW; k++) begin
      c = (rr_ptr + k) % NW;
      if (wi < 0 && wq[c]) wi = c;
    end
    ri = -1;
    for (int k = NR - 1; k >= 0; k--) if (rq[k]) ri = k;
    w_a  = (wi >= 0) ? wa[wi*AW +: AW] : '0;
    w_d  = (wi >= 0) ? wd[wi*DW +: DW] : '0;
    r_a  = (ri >= 0) ? ra[ri*AW +: AW] : '0;
    w_ok = (wi >= 0) && (w_a < NE_A);
    #1;
    chk("init_done", 64'(init_done), 64'(1));
    chk("wr_gnt", 64'(wr_gnt), (wi >= 0) ? (64'(1) << wi) : 64'(0));
    chk("rd_gnt", 64'(rd_gnt), (ri >= 0) ? (64'(1) << ri) : 64'(0));
    chk("rf_rd_addr", 64'(rf_rd_addr), 64'(r_a));
    @(posedge clk); #1;
    exp_rd = (ri >= 0) ? ((r_a < NE_A) ? mdl_mem[r_a] : '0) : prev_rd;
    chk("rf_wr_en", 64'(rf_wr_en), 64'(w_ok));
    if (w_ok) begin
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(w_a));
      chk("rf_wr_data", 64'(rf_wr_data), 64'(w_d));
    end
    chk("rd_valid", 64'(rd_valid), 64'(ri >= 0));
    if (ri >= 0) chk("rd_id", 64'(rd_id), 64'(ri));
    chk("rd_data", 64'(rd_data), 64'(exp_rd));
    chk("addr_err", 64'(addr_err),
        64'(((wi >= 0) && !(w_a < NE_A)) || ((ri >= 0) && !(r_a < NE_A))));
    prev_rd = exp_rd;
    if (pend_v) mdl_mem[pend_a] = pend_d;
    pend_v = w_ok; pend_a = w_a; pend_d = w_d;
    if (wi >= 0) rr_ptr = (wi + 1) % NW;
    @(negedge clk);
  endtask

  task automatic random_cycles(input int unsigned n);
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    logic [NR*AW-1:0] ra;
    for (int unsigned c = 0; c < n; c++) begin
      for (int k = 0; k < NW; k++) begin
        wa[k*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(40, 63))
                                                      : AW'($urandom_range(0, NE - 1));
        wd[k*DW +: DW] = rnd_d();
      end
      for (int k = 0; k < NR; k++)
        ra[k*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(40, 63))
                                                      : AW'($urandom_range(0, NE - 1));
      run_cycle(NW'($urandom()), wa, wd, NR'($urandom()), ra);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    rst = 1'b1; prefill = 1'b1;
    wr_req = '0; wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
    @(negedge clk);
    prefill = 1'b0;

    // Reset, then full clear sweep with all requesters asking
    do_reset(3);
    sweep_check(NE);

    // Round-robin rotation under constant full write request
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NW; k++) begin
        wa[k*AW +: AW] = AW'($urandom_range(6, NE - 1));
        wd[k*DW +: DW] = rnd_d();
      end
      run_cycle(3'b111, wa, wd, 2'b00, 12'h0);
    end

    // Write-to-read visibility at addr 5
    run_cycle(3'b010, {6'd0, 6'd5, 6'd0}, {35'h0, 35'h1_2345_6789, 35'h0}, 2'b00, 12'h0);
    run_cycle(3'b000, 18'h0, 105'h0, 2'b01, {6'd0, 6'd5});
    chk("vis_old", 64'(rd_data), 64'(0));
    run_cycle(3'b000, 18'h0, 105'h0, 2'b01, {6'd0, 6'd5});
    chk("vis_new", 64'(rd_data), 64'(35'h1_2345_6789));

    // Simultaneous reads: requester 0 wins
    run_cycle(3'b000, 18'h0, 105'h0, 2'b11, {6'd8, 6'd5});
    chk("rd_prio_id", 64'(rd_id), 64'(0));

    // Out-of-range write and read in one cycle, then a quiet cycle
    run_cycle(3'b100, {6'd40, 6'd0, 6'd0}, {35'h7_7777_7777, 70'h0}, 2'b10, {6'd63, 6'd0});
    chk("oor_rd_data", 64'(rd_data), 64'(0));
    run_cycle(3'b000, 18'h0, 105'h0, 2'b00, 12'h0);

    random_cycles(300);

    // Reset mid-RUN with a write on the bus
    run_cycle(3'b001, {12'h0, 6'd9}, {70'h0, 35'h2_AAAA_5555}, 2'b00, 12'h0);
    do_reset(2);
    sweep_check(NE);
    random_cycles(60);

    // Reset mid-sweep at address 20
    do_reset(2);
    sweep_check(20);
    #1;
    chk("mid_sweep_addr", 64'(rf_wr_addr), 64'(20));
    do_reset(2);
    sweep_check(NE);
    random_cycles(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
